skinny_inv_sbox8_dom1_hs: RTL and testbench

SKINNY_INV_SBOX8_DOM1_HS -- requirements
Module: skinny_inv_sbox8_dom1_hs

---
 rtl/skinny_inv_sbox8_dom1_hs.sv | 177 +++++++++++++++++
 tb/tb_skinny_inv_sbox8_dom1_hs.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/skinny_inv_sbox8_dom1_hs.sv
// First-order DOM masked inverse SKINNY-128 8-bit S-box with a valid/ready handshake.
// Build option INV_SBOX_NEGEDGE_EN: term registers on negedge clk, one cycle per layer.

module skinny_inv_dom_nor_xor (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    input  logic c0,
    input  logic c1,
    input  logic rk,
    output logic z0,
    output logic z1
);
    // (~a)&(~b)^c: share-1 operands enter inverted, share-0 operands directly.
    logic t_in0, t_in1, t_cr0, t_cr1;

`ifdef INV_SBOX_NEGEDGE_EN
    always_ff @(negedge clk or negedge rst_n) begin
`else
    always_ff @(posedge clk or negedge rst_n) begin
`endif
        if (!rst_n) begin
            t_in0 <= 1'b0;
            t_in1 <= 1'b0;
            t_cr0 <= 1'b0;
            t_cr1 <= 1'b0;
        end else if (en) begin
            t_in0 <= (a0 & b0) ^ c0;
            t_in1 <= (~a1 & ~b1) ^ c1;
            t_cr1 <= (~a1 & b0) ^ rk;
            t_cr0 <= (~b1 & a0) ^ rk;
        end
    end

    assign z0 = t_in0 ^ t_cr0;
    assign z1 = t_in1 ^ t_cr1;
endmodule

module skinny_inv_sbox8_dom1_hs (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] si0,
    input  logic [7:0] si1,
    input  logic [7:0] r,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] bo0,
    output logic [7:0] bo1,
    output logic       out_valid,
    input  logic       out_ready
);
    typedef enum logic [2:0] {IDLE, L1, L2, L3, L4, DONE} state_t;

`ifdef INV_SBOX_NEGEDGE_EN
    localparam logic LAST_PH = 1'b0;
`else
    localparam logic LAST_PH = 1'b1;
`endif

    state_t     state;
    logic       ph;
    logic [7:0] ys0, ys1, rr, xs0, xs1;
    logic [7:0] lmask, term_en;
    logic [7:0] a0, a1, b0, b1, c0, c1, rk;
    logic [7:0] z0, z1, nx0, nx1;

    always_comb begin
        lmask = 8'h00;
        case (state)
            L1:      lmask = 8'hAC;  // x7, x5, x3, x2
            L2:      lmask = 8'h03;  // x1, x0
            L3:      lmask = 8'h40;  // x6
            L4:      lmask = 8'h10;  // x4
            default: lmask = 8'h00;
        endcase
    end

`ifdef INV_SBOX_NEGEDGE_EN
    assign term_en = lmask;
`else
    assign term_en = lmask & {8{~ph}};
`endif

    // Gate operands indexed by the output bit they produce (x7..x0).
    assign a0 = {ys0[2], xs0[2], ys0[6], xs0[7], ys0[7], ys0[3], ys0[5], xs0[3]};
    assign b0 = {ys0[7], xs0[1], ys0[5], xs0[6], ys0[6], ys0[1], xs0[3], xs0[2]};
    assign c0 = {ys0[1], ys0[2], ys0[7], ys0[6], ys0[4], ys0[0], ys0[3], ys0[5]};
    assign a1 = {ys1[2], xs1[2], ys1[6], xs1[7], ys1[7], ys1[3], ys1[5], xs1[3]};
    assign b1 = {ys1[7], xs1[1], ys1[5], xs1[6], ys1[6], ys1[1], xs1[3], xs1[2]};
    assign c1 = {ys1[1], ys1[2], ys1[7], ys1[6], ys1[4], ys1[0], ys1[3], ys1[5]};
    assign rk = {rr[2], rr[6], rr[3], rr[7], rr[1], rr[0], rr[4], rr[5]};

    for (genvar k = 0; k < 8; k++) begin : g_gate
        skinny_inv_dom_nor_xor u_gate (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (term_en[k]),
            .a0    (a0[k]),
            .a1    (a1[k]),
            .b0    (b0[k]),
            .b1    (b1[k]),
            .c0    (c0[k]),
            .c1    (c1[k]),
            .rk    (rk[k]),
            .z0    (z0[k]),
            .z1    (z1[k])
        );
    end

    assign nx0 = (xs0 & ~lmask) | (z0 & lmask);
    assign nx1 = (xs1 & ~lmask) | (z1 & lmask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ph        <= 1'b0;
            ys0       <= 8'h00;
            ys1       <= 8'h00;
            rr        <= 8'h00;
            xs0       <= 8'h00;
            xs1       <= 8'h00;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bo0       <= 8'h00;
            bo1       <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ys0      <= si0;
                        ys1      <= si1;
                        rr       <= r;
                        xs0      <= 8'h00;
                        xs1      <= 8'h00;
                        ph       <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= L1;
                    end
                end
                L1, L2, L3, L4: begin
                    if (ph == LAST_PH) begin
                        xs0 <= nx0;
                        xs1 <= nx1;
                        ph  <= 1'b0;
                        case (state)
                            L1:      state <= L2;
                            L2:      state <= L3;
                            L3:      state <= L4;
                            default: begin
                                state     <= DONE;
                                out_valid <= 1'b1;
                                bo0       <= nx0;
                                bo1       <= nx1;
                            end
                        endcase
                    end else begin
                        ph <= ~ph;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        bo0       <= 8'h00;
                        bo1       <= 8'h00;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_skinny_inv_sbox8_dom1_hs.sv
// Directed bench for skinny_inv_sbox8_dom1_hs; results checked against the forward SKINNY-128 S-box.
module tb_skinny_inv_sbox8_dom1_hs;
`ifdef INV_SBOX_NEGEDGE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 8;
`endif

    logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] si0, si1, r, bo0, bo1;
    int         checks = 0;
    int         errors = 0;

    skinny_inv_sbox8_dom1_hs dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .si0       (si0),
        .si1       (si1),
        .r         (r),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bo0       (bo0),
        .bo1       (bo1),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mix(input logic [7:0] x);
        logic [7:0] t;
        t = ((x >> 1) | x) >> 2;
        return ((~t) & 8'h11) ^ x;
    endfunction

    function automatic logic [7:0] perm(input logic [7:0] x);
        return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5)
             | ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] xin);
        logic [7:0] x;
        x = mix(xin);
        x = mix(perm(x));
        x = mix(perm(x));
        x = mix(perm(x));
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs afterwards, wait (bounded) for the result.
    task automatic do_req(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] rv,
                          input logic [7:0] xexp, input string tag);
        int n;
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        si0 = s0; si1 = s1; r = rv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        si0 = 8'($urandom); si1 = 8'($urandom); r = 8'($urandom);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk8({tag, "_latency"}, 8'(n), 8'(LAT));
        chk8({tag, "_x"}, bo0 ^ bo1, xexp);
        chk1({tag, "_busy"}, in_ready, 1'b0);
    endtask

    task automatic release_req(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk1({tag, "_rel_in_ready"}, in_ready, 1'b1);
        chk1({tag, "_rel_out_valid"}, out_valid, 1'b0);
        chk8({tag, "_rel_bo0"}, bo0, 8'h00);
        chk8({tag, "_rel_bo1"}, bo1, 8'h00);
    endtask

    initial begin
        logic [7:0] hold0, hold1, y, m;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        si0 = 8'h00; si1 = 8'h00; r = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk8("rst_bo0", bo0, 8'h00);
        chk8("rst_bo1", bo1, 8'h00);
        rst_n = 1'b1;

        // Accepted on the first edge after reset release.
        do_req(8'h65, 8'h00, 8'h00, 8'h00, "y65");
        release_req("y65");
        do_req(8'hE9, 8'hA5, 8'h3C, 8'h01, "y4c_r3c");
        release_req("y4c_r3c");
        do_req(8'hE9, 8'hA5, 8'hFF, 8'h01, "y4c_rff");
        release_req("y4c_rff");

        // Consumer stall with in_valid asserted throughout.
        do_req(sbox(8'h5A) ^ 8'h33, 8'h33, 8'h96, 8'h5A, "stall");
        hold0 = bo0; hold1 = bo1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; si0 = 8'($urandom); si1 = 8'($urandom);
            @(posedge clk); #1;
            chk8("stall_bo0", bo0, hold0);
            chk8("stall_bo1", bo1, hold1);
            chk8("stall_x", bo0 ^ bo1, 8'h5A);
            chk1("stall_out_valid", out_valid, 1'b1);
            chk1("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk1("stall_rel_in_ready", in_ready, 1'b1);
        chk1("stall_rel_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk1("stall_no_restart", in_ready, 1'b1);

        // Reset pulse while layer 3 is in flight.
        si0 = 8'hE9; si1 = 8'hA5; r = 8'h3C; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (LAT / 2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk8("midrst_bo0", bo0, 8'h00);
        chk8("midrst_bo1", bo1, 8'h00);
        chk1("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk1("midrst_discarded", out_valid, 1'b0);
        do_req(8'hC3, 8'h3C, 8'h5A, 8'hFF, "after_rst");
        release_req("after_rst");

        // Every y value with random masks and randomness.
        for (int i = 0; i < 256; i++) begin
            y = sbox(8'(i));
            m = 8'($urandom);
            do_req(y ^ m, m, 8'($urandom), 8'(i), "sweep");
            release_req("sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
